// File: rtl/bus_transfer_arbiter_if.sv
// rtl/bus_transfer_arbiter_if.sv - requester/bus-control bundle for the transfer arbiter
interface bus_transfer_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int SEL_W = 5
);
  logic [NREQ-1:0]       req;
  logic [NREQ*SEL_W-1:0] req_src;
  logic [NREQ*SEL_W-1:0] req_dst;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  err;
  logic [SEL_W-1:0]      S;
  logic [SEL_W-1:0]      dst_sel;
  logic                  dst_load;
  logic                  busy;

  modport master (
    output req, req_src, req_dst,
    input  grant, done, err, S, dst_sel, dst_load, busy
  );

  modport slave (
    input  req, req_src, req_dst,
    output grant, done, err, S, dst_sel, dst_load, busy
  );
endinterface

// File: rtl/bus_transfer_arbiter.sv
// rtl/bus_transfer_arbiter.sv - round-robin arbiter and sequencer for the shared datapath bus
module bus_transfer_arbiter #(
  parameter int NREQ     = 4,
  parameter int SEL_W    = 5,
  parameter int NUM_SRC  = 25,
  parameter int PARK_SEL = 0
) (
  input logic                    clock,
  input logic                    clear,
  bus_transfer_arbiter_if.slave  bus
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DRIVE = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_ERR   = 3'd3;
  localparam logic [2:0] ST_WRAP  = 3'd4;

  logic [2:0]       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] winner;
  logic             found;
  logic [SEL_W-1:0] src_w;
  logic [SEL_W-1:0] dst_w;
  logic [SEL_W-1:0] lat_src;
  logic [SEL_W-1:0] lat_dst;

  logic [NREQ-1:0]  grant_r;
  logic [NREQ-1:0]  done_r;
  logic             err_r;
  logic [SEL_W-1:0] s_r;
  logic [SEL_W-1:0] dst_sel_r;
  logic             dst_load_r;
  logic             busy_r;

  // Scan starting at rr_ptr so the requester after the last owner has priority.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx[IDX_W-1:0];
      end
    end
    src_w = bus.req_src[int'(winner)*SEL_W +: SEL_W];
    dst_w = bus.req_dst[int'(winner)*SEL_W +: SEL_W];
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      lat_src    <= '0;
      lat_dst    <= '0;
      grant_r    <= '0;
      done_r     <= '0;
      err_r      <= 1'b0;
      s_r        <= SEL_W'(PARK_SEL);
      dst_sel_r  <= '0;
      dst_load_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      done_r     <= '0;
      err_r      <= 1'b0;
      dst_load_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            grant_r <= NREQ'(1) << winner;
            owner   <= winner;
            lat_src <= src_w;
            lat_dst <= dst_w;
            busy_r  <= 1'b1;
            state   <= (int'(src_w) < NUM_SRC) ? ST_DRIVE : ST_ERR;
          end
        end
        ST_DRIVE: begin
          s_r   <= lat_src;
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          dst_load_r <= 1'b1;
          dst_sel_r  <= lat_dst;
          done_r     <= grant_r;
          state      <= ST_WRAP;
        end
        ST_ERR: begin
          done_r <= grant_r;
          err_r  <= 1'b1;
          state  <= ST_WRAP;
        end
        ST_WRAP: begin
          // Release cycle guarantees at least one idle cycle between transfers.
          grant_r <= '0;
          s_r     <= SEL_W'(PARK_SEL);
          busy_r  <= 1'b0;
          rr_ptr  <= (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant    = grant_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;
  assign bus.S        = s_r;
  assign bus.dst_sel  = dst_sel_r;
  assign bus.dst_load = dst_load_r;
  assign bus.busy     = busy_r;
endmodule

// File: tb/tb_bus_transfer_arbiter.sv
// tb/tb_bus_transfer_arbiter.sv - randomized and directed bench for bus_transfer_arbiter
module tb_bus_transfer_arbiter;
  localparam int NREQ     = 4;
  localparam int SEL_W    = 5;
  localparam int NUM_SRC  = 25;
  localparam int PARK_SEL = 0;

  logic clock;
  logic clear;
  logic [NREQ-1:0]  req_v;
  logic [SEL_W-1:0] src_v [NREQ];
  logic [SEL_W-1:0] dst_v [NREQ];

  int n_tests;
  int n_fail;

  bus_transfer_arbiter_if #(.NREQ(NREQ), .SEL_W(SEL_W)) bus ();

  bus_transfer_arbiter #(
    .NREQ(NREQ), .SEL_W(SEL_W), .NUM_SRC(NUM_SRC), .PARK_SEL(PARK_SEL)
  ) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    bus.req     = req_v;
    bus.req_src = '0;
    bus.req_dst = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_src[i*SEL_W +: SEL_W] = src_v[i];
      bus.req_dst[i*SEL_W +: SEL_W] = dst_v[i];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: k counts cycles since the grant edge; 0 = idle.
  int              m_k;
  int              m_w;
  int              m_rr;
  bit              m_legal;
  logic [SEL_W-1:0] m_src;
  logic [SEL_W-1:0] m_dst;
  logic [SEL_W-1:0] m_dst_sel;
  int              wait_cnt [NREQ];

  task automatic model_edge();
    bit hit;
    if (clear) begin
      m_k = 0; m_rr = 0; m_dst_sel = '0;
      for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
      return;
    end
    if (m_k == 0) begin
      if (req_v != '0) begin
        hit = 0;
        for (int j = 0; j < NREQ; j++) begin
          int c;
          c = (m_rr + j) % NREQ;
          if (!hit && req_v[c]) begin hit = 1; m_w = c; end
        end
        check_eq("fairness", (wait_cnt[m_w] <= NREQ - 1) ? 1 : 0, 1);
        for (int i = 0; i < NREQ; i++)
          wait_cnt[i] = (i != m_w && req_v[i]) ? wait_cnt[i] + 1 : 0;
        m_src   = src_v[m_w];
        m_dst   = dst_v[m_w];
        m_legal = (int'(m_src) < NUM_SRC);
        m_k     = 1;
      end
    end else if (m_k == (m_legal ? 3 : 2)) begin
      m_k  = 0;
      m_rr = (m_w + 1) % NREQ;
    end else begin
      m_k++;
      if (m_legal && m_k == 3) m_dst_sel = m_dst;
    end
  endtask

  task automatic compare();
    logic [NREQ-1:0] e_one;
    bit fin;
    e_one = (m_k != 0) ? (NREQ'(1) << m_w) : '0;
    fin   = (m_legal && m_k == 3) || (!m_legal && m_k == 2);
    check_eq("grant",    bus.grant, e_one);
    check_eq("busy",     bus.busy, (m_k != 0) ? 1 : 0);
    check_eq("S",        bus.S, (m_legal && m_k >= 2) ? m_src : SEL_W'(PARK_SEL));
    check_eq("dst_load", bus.dst_load, (m_legal && m_k == 3) ? 1 : 0);
    check_eq("dst_sel",  bus.dst_sel, m_dst_sel);
    check_eq("done",     bus.done, fin ? e_one : '0);
    check_eq("err",      bus.err, (!m_legal && m_k == 2) ? 1 : 0);
    check_eq("grant_1hot", ($countones(bus.grant) <= 1) ? 1 : 0, 1);
    check_eq("S_legal",  (int'(bus.S) < NUM_SRC) ? 1 : 0, 1);
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare();
  endtask

  task automatic do_reset();
    clear = 1'b1;
    req_v = '0;
    cycle();
    cycle();
    clear = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_k = 0; m_w = 0; m_rr = 0; m_legal = 1; m_src = '0; m_dst = '0; m_dst_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      src_v[i] = SEL_W'(i + 1);
      dst_v[i] = SEL_W'(i + 8);
      wait_cnt[i] = 0;
    end
    clear = 1'b1;
    req_v = '0;
    do_reset();
    check_eq("reset_grant", bus.grant, 0);
    check_eq("reset_S", bus.S, PARK_SEL);

    // single transfer with explicit timeline
    src_v[0] = 5'd5; dst_v[0] = 5'd17; req_v = 4'b0001;
    cycle(); check_eq("t1_grant", bus.grant, 4'b0001);
    cycle(); check_eq("t1_S", bus.S, 5);
    cycle(); check_eq("t1_load", bus.dst_load, 1);
             check_eq("t1_dst", bus.dst_sel, 17);
             check_eq("t1_done", bus.done, 4'b0001);
    req_v = '0;
    cycle(); check_eq("t1_idle", bus.busy, 0);
    repeat (2) cycle();

    // contention from reset
    do_reset();
    req_v = 4'b1111;
    repeat (20) cycle();
    req_v = '0;
    repeat (4) cycle();

    // illegal source
    src_v[2] = 5'd27; req_v = 4'b0100;
    cycle(); check_eq("t3_grant", bus.grant, 4'b0100);
    cycle(); check_eq("t3_err", bus.err, 1);
             check_eq("t3_done", bus.done, 4'b0100);
    req_v = '0;
    repeat (3) cycle();
    src_v[2] = 5'd3;

    // clear in the DRIVE cycle
    req_v = 4'b0001;
    cycle();
    clear = 1'b1;
    cycle(); check_eq("t4_grant", bus.grant, 0);
    clear = 1'b0; req_v = 4'b0011;
    cycle(); check_eq("t4_rr", bus.grant, 4'b0001);
    req_v = '0;
    repeat (4) cycle();

    // early drop of req1 during DRIVE
    do_reset();
    req_v = 4'b0010;
    cycle();
    req_v = 4'b0100;
    repeat (3) cycle();
    cycle(); check_eq("t5_next", bus.grant, 4'b0100);
    req_v = '0;
    repeat (4) cycle();

    // req0 held, req3 raised once
    req_v = 4'b0001;
    repeat (3) cycle();
    req_v = 4'b1001;
    repeat (10) cycle();
    req_v = '0;
    repeat (4) cycle();

    // randomized traffic with occasional clears
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 3) == 0) req_v[i] = ~req_v[i];
        if ($urandom_range(0, 2) == 0) src_v[i] = SEL_W'($urandom_range(0, 31));
        if ($urandom_range(0, 2) == 0) dst_v[i] = SEL_W'($urandom_range(0, 31));
      end
      clear = ($urandom_range(0, 63) == 0);
      cycle();
    end
    clear = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
